// File: rtl/ifetch_prefetch_buffer.sv
// -----------------------------------------------------------------------------
// ifetch_prefetch_buffer
//
// Instruction prefetch queue sitting between the instruction memory bus and the
// IF stage of the RV32IM core. It issues sequential word fetches ahead of the
// core, absorbs variable memory latency, and hands the core {pc, instr, pc+4}
// through a valid/ready handshake. A redirect flushes the queue and arranges for
// the responses that are still in flight to be thrown away.
//
// Parameters
//   RESET_PC         first fetch address after reset (word aligned)
//   DEPTH            queue entries (power of 2, >= 2)
//   MAX_OUTSTANDING  memory requests in flight, counting ones being dropped
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   redirect_valid_i    restart the fetch stream at redirect_pc_i this cycle
//   redirect_pc_i       new fetch PC (bits [1:0] ignored)
//   imem_req_valid_o    fetch request valid
//   imem_req_addr_o     fetch word address
//   imem_req_ready_i    memory accepts the request
//   imem_resp_valid_i   read data valid (in request order, latency >= 1)
//   imem_resp_rdata_i   instruction word
//   if_valid_o          queue head valid
//   if_pc_o             PC of head instruction
//   if_instr_o          head instruction word
//   if_pc_plus_4_o      if_pc_o + 4 (mod 2^32)
//   if_ready_i          core consumes the head this cycle
// -----------------------------------------------------------------------------
module ifetch_prefetch_buffer #(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int          DEPTH           = 4,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_valid_o,
    output logic [31:0] imem_req_addr_o,
    input  logic        imem_req_ready_i,
    input  logic        imem_resp_valid_i,
    input  logic [31:0] imem_resp_rdata_i,
    output logic        if_valid_o,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_instr_o,
    output logic [31:0] if_pc_plus_4_o,
    input  logic        if_ready_i
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int OW = $clog2(MAX_OUTSTANDING) + 1;

    logic [31:0]   fetch_pc;   // address of the next request to issue
    logic [31:0]   resp_pc;    // PC belonging to the next kept response
    logic [CW-1:0] count;      // valid queue entries
    logic [OW-1:0] inflight;   // issued requests whose data will be kept
    logic [OW-1:0] drop;       // issued requests whose data will be discarded
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          started;    // holds requests off for the cycle after reset

    logic [31:0]   pc_mem    [DEPTH];
    logic [31:0]   instr_mem [DEPTH];

    logic          have_room;
    logic          have_credit;
    logic          req_fire;
    logic          resp_live;
    logic          push;
    logic          pop;
    logic [31:0]   redirect_pc_aligned;
    logic          unused_redirect_lsbs;

    assign redirect_pc_aligned  = {redirect_pc_i[31:2], 2'b00};
    assign unused_redirect_lsbs = ^redirect_pc_i[1:0];

    // Every issued, kept request owns a queue slot, so a response can always
    // be pushed even when the core is not popping.
    assign have_room   = (32'(count) + 32'(inflight)) < 32'(DEPTH);
    assign have_credit = (32'(inflight) + 32'(drop)) < 32'(MAX_OUTSTANDING);

    // Credit only grows while a request waits, so valid/addr stay stable
    // until the handshake without any extra holding logic.
    assign imem_req_valid_o = started & ~rst & ~redirect_valid_i & have_room & have_credit;
    assign imem_req_addr_o  = fetch_pc;
    assign req_fire         = imem_req_valid_o & imem_req_ready_i;

    // A response with nothing outstanding is a protocol error and is ignored.
    assign resp_live = imem_resp_valid_i & ((inflight != '0) | (drop != '0));
    assign push      = ~rst & ~redirect_valid_i & resp_live & (drop == '0);

    assign if_valid_o     = ~rst & ~redirect_valid_i & (count != '0);
    assign pop            = if_valid_o & if_ready_i;
    assign if_pc_o        = pc_mem[rd_ptr];
    assign if_instr_o     = instr_mem[rd_ptr];
    assign if_pc_plus_4_o = pc_mem[rd_ptr] + 32'd4;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            resp_pc  <= RESET_PC;
            count    <= '0;
            inflight <= '0;
            drop     <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            started  <= 1'b0;
        end else begin
            started <= 1'b1;
            if (redirect_valid_i) begin
                // Everything still in flight becomes a dropped response; one
                // arriving this very cycle is already consumed here.
                fetch_pc <= redirect_pc_aligned;
                resp_pc  <= redirect_pc_aligned;
                count    <= '0;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                inflight <= '0;
                drop     <= drop + inflight - OW'(resp_live);
            end else begin
                if (req_fire) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (push) begin
                    resp_pc <= resp_pc + 32'd4;
                    wr_ptr  <= wr_ptr + PW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
                count    <= count + CW'(push) - CW'(pop);
                inflight <= inflight + OW'(req_fire) - OW'(push);
                if (resp_live && (drop != '0)) begin
                    drop <= drop - OW'(1);
                end
            end
        end
    end

    // NOTE: queue storage is not reset; count and the pointers decide which
    // entries hold meaningful data, so clearing the array would be wasted logic.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]    <= resp_pc;
            instr_mem[wr_ptr] <= imem_resp_rdata_i;
        end
    end

endmodule

// File: tb/tb_ifetch_prefetch_buffer.sv
// -----------------------------------------------------------------------------
// tb_ifetch_prefetch_buffer
//
// Self-checking bench for ifetch_prefetch_buffer. An in-order memory model with
// configurable latency answers requests; every accepted request pushes the
// expected {pc, instr} onto a scoreboard that is popped and compared whenever
// the core side consumes an instruction. A redirect empties the scoreboard and
// restarts the expected address stream. Redirect targets with their expected
// delivered PCs are kept in a vector table; the multi-cycle corner cases are
// written out as hand sequences.
// -----------------------------------------------------------------------------
module tb_ifetch_prefetch_buffer;

    localparam int MAX_OUT = 2;

    logic        clk;
    logic        rst;
    logic        redirect_valid_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_valid_o;
    logic [31:0] imem_req_addr_o;
    logic        imem_req_ready_i;
    logic        imem_resp_valid_i;
    logic [31:0] imem_resp_rdata_i;
    logic        if_valid_o;
    logic [31:0] if_pc_o;
    logic [31:0] if_instr_o;
    logic [31:0] if_pc_plus_4_o;
    logic        if_ready_i;

    ifetch_prefetch_buffer #(
        .RESET_PC        (32'h0000_0000),
        .DEPTH           (4),
        .MAX_OUTSTANDING (MAX_OUT)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .redirect_valid_i  (redirect_valid_i),
        .redirect_pc_i     (redirect_pc_i),
        .imem_req_valid_o  (imem_req_valid_o),
        .imem_req_addr_o   (imem_req_addr_o),
        .imem_req_ready_i  (imem_req_ready_i),
        .imem_resp_valid_i (imem_resp_valid_i),
        .imem_resp_rdata_i (imem_resp_rdata_i),
        .if_valid_o        (if_valid_o),
        .if_pc_o           (if_pc_o),
        .if_instr_o        (if_instr_o),
        .if_pc_plus_4_o    (if_pc_plus_4_o),
        .if_ready_i        (if_ready_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } sb_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] p4;
    } pop_t;

    typedef struct {
        logic [31:0] rpc;
        logic [31:0] pc0;
        logic [31:0] pc1;
        logic [31:0] pc2;
        logic [31:0] p40;
        logic [31:0] p41;
        logic [31:0] p42;
    } vec_t;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          rel_cyc = 0;
    int          first_if_cyc = -1;
    int          mem_lat = 1;
    bit          rand_ready = 1'b0;

    pend_t       pend[$];
    sb_t         sb[$];
    pop_t        pop_log[$];
    logic [31:0] hs_log[$];
    logic [31:0] exp_req_addr = 32'h0;

    logic        s_req_valid;
    logic [31:0] s_req_addr;
    logic        s_if_valid;
    logic [31:0] s_if_pc;
    logic [31:0] s_if_instr;
    logic [31:0] s_if_p4;
    logic        stall_prev = 1'b0;
    logic [31:0] stall_addr = 32'h0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock cycle. Entered at the falling edge with the test-driven inputs
    // already set; drives the memory model, samples, scores, then advances.
    task automatic cycle();
        sb_t  e;
        pop_t p;
        imem_resp_valid_i = 1'b0;
        imem_resp_rdata_i = 32'h0;
        if (!rst && pend.size() > 0 && pend[0].due <= cyc) begin
            imem_resp_valid_i = 1'b1;
            imem_resp_rdata_i = mem_word(pend[0].addr);
            void'(pend.pop_front());
        end
        imem_req_ready_i = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        #1;
        s_req_valid = imem_req_valid_o;
        s_req_addr  = imem_req_addr_o;
        s_if_valid  = if_valid_o;
        s_if_pc     = if_pc_o;
        s_if_instr  = if_instr_o;
        s_if_p4     = if_pc_plus_4_o;
        if (!rst) begin
            if (stall_prev && !redirect_valid_i) begin
                check("req_hold_valid", 32'(s_req_valid), 32'd1);
                check("req_hold_addr", s_req_addr, stall_addr);
            end
            if (redirect_valid_i) begin
                check("redirect_req_valid", 32'(s_req_valid), 32'd0);
                check("redirect_if_valid", 32'(s_if_valid), 32'd0);
            end
            if (s_req_valid && imem_req_ready_i) begin
                check("req_addr", s_req_addr, exp_req_addr);
                pend.push_back('{addr: s_req_addr, due: cyc + mem_lat});
                check("outstanding_le_max", 32'(pend.size() <= MAX_OUT), 32'd1);
                sb.push_back('{pc: exp_req_addr, instr: mem_word(exp_req_addr)});
                hs_log.push_back(s_req_addr);
                exp_req_addr = exp_req_addr + 32'd4;
            end
            if (s_if_valid && if_ready_i) begin
                check("pop_expected_present", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("pop_pc", s_if_pc, e.pc);
                    check("pop_instr", s_if_instr, e.instr);
                    check("pop_pc_plus_4", s_if_p4, e.pc + 32'd4);
                end
                p.pc = s_if_pc;
                p.p4 = s_if_p4;
                pop_log.push_back(p);
                if (first_if_cyc < 0) first_if_cyc = cyc;
            end
            if (redirect_valid_i) begin
                sb.delete();
                exp_req_addr = {redirect_pc_i[31:2], 2'b00};
            end
            stall_prev = s_req_valid && !imem_req_ready_i;
            stall_addr = s_req_addr;
        end else begin
            stall_prev = 1'b0;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    // Two reset cycles plus the first cycle after release, all with both
    // valids low. Memory model state is cleared together with the DUT.
    task automatic do_reset();
        rst = 1'b1;
        redirect_valid_i = 1'b0;
        pend.delete();
        sb.delete();
        exp_req_addr = 32'h0;
        for (int i = 0; i < 2; i++) begin
            cycle();
            check("reset_req_valid", 32'(s_req_valid), 32'd0);
            check("reset_if_valid", 32'(s_if_valid), 32'd0);
        end
        rst = 1'b0;
        hs_log.delete();
        pop_log.delete();
        first_if_cyc = -1;
        rel_cyc = cyc;
        cycle();
        check("post_reset_req_valid", 32'(s_req_valid), 32'd0);
        check("post_reset_if_valid", 32'(s_if_valid), 32'd0);
    endtask

    task automatic run_until_pops(input int n, input int budget, input string name);
        int k = 0;
        while (pop_log.size() < n && k < budget) begin
            cycle();
            k++;
        end
        check(name, 32'(pop_log.size() >= n), 32'd1);
    endtask

    task automatic run_until_hs(input int n, input int budget, input string name);
        int k = 0;
        while (hs_log.size() < n && k < budget) begin
            cycle();
            k++;
        end
        check(name, 32'(hs_log.size() >= n), 32'd1);
    endtask

    task automatic redirect_to(input logic [31:0] pc);
        redirect_valid_i = 1'b1;
        redirect_pc_i    = pc;
        cycle();
        redirect_valid_i = 1'b0;
    endtask

    initial begin
        vec_t vecs[4];
        int   np;
        int   nh;
        int   k;

        vecs[0] = '{32'h0000_0103, 32'h0000_0100, 32'h0000_0104, 32'h0000_0108,
                    32'h0000_0104, 32'h0000_0108, 32'h0000_010C};
        vecs[1] = '{32'hFFFF_FFF8, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000,
                    32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
        vecs[2] = '{32'h7FFF_FFFE, 32'h7FFF_FFFC, 32'h8000_0000, 32'h8000_0004,
                    32'h8000_0000, 32'h8000_0004, 32'h8000_0008};
        vecs[3] = '{32'h0000_0001, 32'h0000_0000, 32'h0000_0004, 32'h0000_0008,
                    32'h0000_0004, 32'h0000_0008, 32'h0000_000C};

        rst               = 1'b1;
        redirect_valid_i  = 1'b0;
        redirect_pc_i     = 32'h0;
        imem_req_ready_i  = 1'b1;
        imem_resp_valid_i = 1'b0;
        imem_resp_rdata_i = 32'h0;
        if_ready_i        = 1'b1;
        @(negedge clk);

        // Streaming from reset: 1-cycle memory, core always ready.
        mem_lat = 1;
        if_ready_i = 1'b1;
        do_reset();
        cycle();
        check("t1_first_req_valid", 32'(s_req_valid), 32'd1);
        check("t1_first_req_addr", s_req_addr, 32'h0);
        run_until_pops(4, 20, "t1_pops_timeout");
        check("t1_first_if_valid_cycle", 32'(first_if_cyc - rel_cyc), 32'd3);
        if (pop_log.size() >= 4) begin
            check("t1_pop0_pc", pop_log[0].pc, 32'h0);
            check("t1_pop3_pc", pop_log[3].pc, 32'hC);
        end

        // Core stalled: exactly DEPTH requests, then fetch stops.
        do_reset();
        if_ready_i = 1'b0;
        repeat (15) cycle();
        check("t2_requests_when_full", 32'(hs_log.size()), 32'd4);
        check("t2_req_valid_when_full", 32'(s_req_valid), 32'd0);
        check("t2_if_valid_when_full", 32'(s_if_valid), 32'd1);
        if_ready_i = 1'b1;
        run_until_pops(4, 20, "t2_pops_timeout");
        run_until_hs(5, 20, "t2_resume_timeout");
        if (pop_log.size() >= 4) begin
            check("t2_pop0_pc", pop_log[0].pc, 32'h0);
            check("t2_pop1_pc", pop_log[1].pc, 32'h4);
            check("t2_pop2_pc", pop_log[2].pc, 32'h8);
            check("t2_pop3_pc", pop_log[3].pc, 32'hC);
        end
        if (hs_log.size() >= 5) check("t2_resume_addr", hs_log[4], 32'h10);

        // Redirect with two requests in flight: both responses dropped.
        do_reset();
        mem_lat = 5;
        if_ready_i = 1'b1;
        k = 0;
        while (!(hs_log.size() > 0 && hs_log[hs_log.size()-1] == 32'h24) && k < 100) begin
            cycle();
            k++;
        end
        check("t3_reach_0x24", 32'(k < 100), 32'd1);
        check("t3_two_outstanding", 32'(pend.size()), 32'd2);
        nh = hs_log.size();
        np = pop_log.size();
        redirect_to(32'h0000_0103);
        run_until_hs(nh + 1, 30, "t3_req_timeout");
        if (hs_log.size() > nh) check("t3_first_req_after_redirect", hs_log[nh], 32'h100);
        run_until_pops(np + 1, 40, "t3_pop_timeout");
        if (pop_log.size() > np) check("t3_first_pc_after_redirect", pop_log[np].pc, 32'h100);

        // Redirect coinciding with a response and a pop.
        do_reset();
        mem_lat = 3;
        if_ready_i = 1'b0;
        run_until_hs(4, 30, "t4_fill_timeout");
        k = 0;
        while (!(pend.size() > 0 && pend[0].due <= cyc) && k < 20) begin
            cycle();
            k++;
        end
        check("t4_queue_nonempty", 32'(s_if_valid), 32'd1);
        check("t4_second_outstanding", 32'(pend.size()), 32'd2);
        np = pop_log.size();
        if_ready_i = 1'b1;
        redirect_to(32'h0000_0200);
        check("t4_pop_ignored", 32'(pop_log.size()), 32'(np));
        cycle();
        check("t4_req_next_cycle", 32'(s_req_valid), 32'd1);
        check("t4_req_next_addr", s_req_addr, 32'h200);
        run_until_pops(np + 2, 40, "t4_pop_timeout");
        if (pop_log.size() >= np + 2) begin
            check("t4_first_pc", pop_log[np].pc, 32'h200);
            check("t4_second_pc", pop_log[np + 1].pc, 32'h204);
        end

        // Long latency, random memory ready and random core ready.
        do_reset();
        mem_lat = 5;
        rand_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if_ready_i = 1'($urandom_range(0, 1));
            cycle();
        end
        rand_ready = 1'b0;
        if_ready_i = 1'b1;
        repeat (20) cycle();
        check("t5_progress", 32'(pop_log.size() >= 20), 32'd1);

        // Redirect target table, applied back to back on a running stream.
        do_reset();
        mem_lat = 1;
        if_ready_i = 1'b1;
        repeat (5) cycle();
        for (int v = 0; v < 4; v++) begin
            np = pop_log.size();
            redirect_to(vecs[v].rpc);
            run_until_pops(np + 3, 40, "vec_pop_timeout");
            if (pop_log.size() >= np + 3) begin
                check("vec_pc0", pop_log[np].pc, vecs[v].pc0);
                check("vec_pc1", pop_log[np + 1].pc, vecs[v].pc1);
                check("vec_pc2", pop_log[np + 2].pc, vecs[v].pc2);
                check("vec_p4_0", pop_log[np].p4, vecs[v].p40);
                check("vec_p4_1", pop_log[np + 1].p4, vecs[v].p41);
                check("vec_p4_2", pop_log[np + 2].p4, vecs[v].p42);
            end
        end

        // Back-to-back redirects: the last one wins.
        np = pop_log.size();
        redirect_valid_i = 1'b1;
        redirect_pc_i    = 32'h0000_0300;
        cycle();
        redirect_pc_i    = 32'h0000_0404;
        cycle();
        redirect_valid_i = 1'b0;
        run_until_pops(np + 2, 40, "b2b_pop_timeout");
        if (pop_log.size() >= np + 2) begin
            check("b2b_pc0", pop_log[np].pc, 32'h404);
            check("b2b_pc1", pop_log[np + 1].pc, 32'h408);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
